crsr_overlay_mc: RTL

- Multi-cursor hardware overlay stage in the LCD pixel pipeline, after palette/format conversion and before the output FIFO.
- Overlays up to NUM_CRSR independent 2-bpp cursors (32x32 or 64x64) onto a valid/ready pixel stream.
- Fixed-index priority between cursors; per-cursor palettes, clipping and frame-synchronised position update.
- Each cursor has its own 1-cycle-latency image RAM read port.

---
 rtl/crsr_pkg.sv | 22 ++
 rtl/crsr_hit_addr.sv | 85 ++++++++
 rtl/crsr_overlay_mc.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/crsr_pkg.sv
// Shared types and helpers for the multi-cursor overlay.
package crsr_pkg;

    typedef enum logic [1:0] {
        CODE_PAL0   = 2'b00,
        CODE_PAL1   = 2'b01,
        CODE_TRANSP = 2'b10,
        CODE_INV    = 2'b11
    } crsr_code_e;

    localparam logic [5:0] SIZE32_M1 = 6'd31;
    localparam logic [5:0] SIZE64_M1 = 6'd63;

    // Pixel k of a 16-pixel word: bytes in little-endian order, but within a
    // byte the leftmost pixel sits in the top two bits.
    function automatic crsr_code_e pick_code(input logic [31:0] word, input logic [3:0] k);
        logic [4:0] lo;
        lo = {k[3:2], 3'b110} - {2'b00, k[1:0], 1'b0};
        return crsr_code_e'(word[lo +: 2]);
    endfunction

endpackage

// File: rtl/crsr_hit_addr.sv
// One cursor: position/clip shadow registers plus combinational hit test and
// image RAM address for the pixel currently at the input.
module crsr_hit_addr
    import crsr_pkg::*;
#(
    parameter int X_W = 10,
    parameter int Y_W = 10,
    parameter int AW  = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic [X_W-1:0] x_in,
    input  logic [Y_W-1:0] y_in,
    input  logic [5:0]     clip_x_in,
    input  logic [5:0]     clip_y_in,
    input  logic [X_W-1:0] col,
    input  logic [Y_W-1:0] row,
    input  logic           on,
    input  logic           size64,
    input  logic [1:0]     img,
    output logic           hit,
    output logic [3:0]     pix_k,
    output logic [AW-1:0]  addr
);

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic [5:0]     cx_q, cx_d, cy_q, cy_d;

    logic [5:0]     size_m1;
    logic [X_W:0]   dx;
    logic [Y_W:0]   dy;
    logic [6:0]     lim_x, lim_y;
    logic [5:0]     ix, iy;
    logic [7:0]     addr8;

    // Shadow next-state: take the live values whenever a load is requested.
    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        cx_d = cx_q;
        cy_d = cy_q;
        if (load) begin
            x_d  = x_in;
            y_d  = y_in;
            cx_d = clip_x_in;
            cy_d = clip_y_in;
        end
    end

    // Shadow registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q  <= '0;
            y_q  <= '0;
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

    // Hit test with one extra bit on every difference: the top bit of dx/dy is
    // "left of / above the cursor", the top bit of lim is "clip exceeds size".
    always_comb begin
        size_m1 = size64 ? SIZE64_M1 : SIZE32_M1;
        dx      = {1'b0, col} - {1'b0, x_q};
        dy      = {1'b0, row} - {1'b0, y_q};
        lim_x   = {1'b0, size_m1} - {1'b0, cx_q};
        lim_y   = {1'b0, size_m1} - {1'b0, cy_q};
        ix      = dx[5:0] + cx_q;
        iy      = dy[5:0] + cy_q;
        hit     = on & ~dx[X_W] & ~dy[Y_W] & ~lim_x[6] & ~lim_y[6]
                & (dx <= {{(X_W-5){1'b0}}, lim_x[5:0]})
                & (dy <= {{(Y_W-5){1'b0}}, lim_y[5:0]});
        addr8   = size64 ? {iy, ix[5:4]} : {img, iy[4:0], ix[4]};
        addr    = AW'(addr8);
        pix_k   = ix[3:0];
    end

endmodule

// File: rtl/crsr_overlay_mc.sv
// Multi-cursor overlay: raster counters, two-stage valid/ready pipeline
// around the per-cursor image RAM reads, and the fixed-priority colour mux.
module crsr_overlay_mc
    import crsr_pkg::*;
#(
    parameter int PIX_W    = 24,
    parameter int NUM_CRSR = 2,
    parameter int X_W      = 10,
    parameter int Y_W      = 10,
    parameter int AW       = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    vsync,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [PIX_W-1:0]        s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [PIX_W-1:0]        m_data,
    input  logic [X_W-1:0]          ppl_m1,
    input  logic [Y_W-1:0]          lpp_m1,
    input  logic                    frame_sync,
    input  logic                    size64,
    input  logic [NUM_CRSR-1:0]     crsr_on,
    input  logic [2*NUM_CRSR-1:0]   crsr_img,
    input  logic [X_W*NUM_CRSR-1:0] crsr_x,
    input  logic [Y_W*NUM_CRSR-1:0] crsr_y,
    input  logic [6*NUM_CRSR-1:0]   clip_x,
    input  logic [6*NUM_CRSR-1:0]   clip_y,
    input  logic [PIX_W*NUM_CRSR-1:0] pal0,
    input  logic [PIX_W*NUM_CRSR-1:0] pal1,
    output logic [NUM_CRSR-1:0]     mem_ren,
    output logic [AW*NUM_CRSR-1:0]  mem_raddr,
    input  logic [32*NUM_CRSR-1:0]  mem_rdata
);

    logic                  adv, accept, vs_rise, shadow_load;
    logic                  vsync_q, vsync_d;
    logic [X_W-1:0]        col_q, col_d, pix_col;
    logic [Y_W-1:0]        row_q, row_d, pix_row;

    logic [NUM_CRSR-1:0]   hit;
    logic [4*NUM_CRSR-1:0] pix_k;
    logic [AW*NUM_CRSR-1:0] addr;

    logic                  p0_valid_q, p0_valid_d;
    logic [PIX_W-1:0]      p0_data_q, p0_data_d;
    logic [NUM_CRSR-1:0]   p0_hit_q, p0_hit_d;
    logic [4*NUM_CRSR-1:0] p0_k_q, p0_k_d;
    logic                  m_valid_q, m_valid_d;
    logic [PIX_W-1:0]      m_data_q, m_data_d;
    logic [PIX_W-1:0]      out_pix;
    crsr_code_e            code;

    // The whole pipeline moves as one; the RAMs hold their output while stalled.
    assign adv         = m_ready | ~m_valid_q;
    assign accept      = s_valid & adv;
    assign vs_rise     = vsync & ~vsync_q;
    assign shadow_load = ~frame_sync | vs_rise;
    assign pix_col     = vs_rise ? '0 : col_q;
    assign pix_row     = vs_rise ? '0 : row_q;

    assign s_ready   = adv;
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign mem_ren   = {NUM_CRSR{adv & ~reset}};
    assign mem_raddr = reset ? '0 : addr;

    for (genvar gi = 0; gi < NUM_CRSR; gi++) begin : g_crsr
        crsr_hit_addr #(
            .X_W (X_W),
            .Y_W (Y_W),
            .AW  (AW)
        ) u_hit_addr (
            .clk       (clk),
            .reset     (reset),
            .load      (shadow_load),
            .x_in      (crsr_x[X_W*gi +: X_W]),
            .y_in      (crsr_y[Y_W*gi +: Y_W]),
            .clip_x_in (clip_x[6*gi +: 6]),
            .clip_y_in (clip_y[6*gi +: 6]),
            .col       (pix_col),
            .row       (pix_row),
            .on        (crsr_on[gi]),
            .size64    (size64),
            .img       (crsr_img[2*gi +: 2]),
            .hit       (hit[gi]),
            .pix_k     (pix_k[4*gi +: 4]),
            .addr      (addr[AW*gi +: AW])
        );
    end

    // Raster position: advance per accepted pixel, vsync edge wins over it.
    always_comb begin
        vsync_d = vsync;
        col_d   = col_q;
        row_d   = row_q;
        if (vs_rise) begin
            col_d = '0;
            row_d = '0;
        end else if (accept) begin
            if (col_q == ppl_m1) begin
                col_d = '0;
                row_d = (row_q == lpp_m1) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Lowest-index cursor with an opaque code wins, so walk from the top down.
    always_comb begin
        out_pix = p0_data_q;
        code    = CODE_TRANSP;
        for (int i = NUM_CRSR - 1; i >= 0; i--) begin
            code = pick_code(mem_rdata[32*i +: 32], p0_k_q[4*i +: 4]);
            if (p0_hit_q[i]) begin
                case (code)
                    CODE_PAL0: out_pix = pal0[PIX_W*i +: PIX_W];
                    CODE_PAL1: out_pix = pal1[PIX_W*i +: PIX_W];
                    CODE_INV:  out_pix = ~p0_data_q;
                    default:   ;
                endcase
            end
        end
    end

    // Pipeline next-state: both stages load together whenever adv is high.
    always_comb begin
        p0_valid_d = p0_valid_q;
        p0_data_d  = p0_data_q;
        p0_hit_d   = p0_hit_q;
        p0_k_d     = p0_k_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        if (adv) begin
            p0_valid_d = s_valid;
            p0_data_d  = s_data;
            p0_hit_d   = hit;
            p0_k_d     = pix_k;
            m_valid_d  = p0_valid_q;
            m_data_d   = out_pix;
        end
    end

    // State registers; reset empties the pipeline at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_q    <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            p0_valid_q <= 1'b0;
            p0_data_q  <= '0;
            p0_hit_q   <= '0;
            p0_k_q     <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
        end else begin
            vsync_q    <= vsync_d;
            col_q      <= col_d;
            row_q      <= row_d;
            p0_valid_q <= p0_valid_d;
            p0_data_q  <= p0_data_d;
            p0_hit_q   <= p0_hit_d;
            p0_k_q     <= p0_k_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
        end
    end

endmodule
